// File: rtl/bk_save_ctrl.sv
// rtl/bk_save_ctrl.sv - cart battery-save loader/saver between SD sector buffer and cart RAM
module bk_save_ctrl #(
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        has_save,
  input  logic [7:0]  ram_mask_file,
  input  logic        bk_save_req,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  input  logic [15:0] bk_q,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [15:0] sd_buff_din,
  output logic [16:0] bk_addr,
  output logic [15:0] bk_data,
  output logic        bk_wr,
  output logic        bk_loading,
  output logic        bk_busy,
  output logic        bk_error
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_XFER,
    WR_REQ,
    WR_XFER,
    NEXT
  } state_t;

  // Abort fires on the last waiting cycle, giving 2^W-1 request cycles in total.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_lba;
  logic [7:0]           r_mask;
  logic                 r_pending;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_loading;
  logic                 r_error;
  logic                 r_save_req_d;

  logic w_img_present;
  logic w_load_ok;
  logic w_save_qual;
  logic w_wd_last;
  logic w_start_load;
  logic w_start_save;
  logic w_lba_inc;
  logic w_timeout;
  logic w_done;
  logic w_wd_inc;

  assign w_img_present = (img_size != 64'd0);
  assign w_load_ok     = img_mounted & w_img_present & has_save;
  assign w_save_qual   = bk_save_req & ~r_save_req_d & has_save & w_img_present & ~img_readonly;
  assign w_wd_last     = (r_wd == WD_LAST);

  always_comb begin
    w_next_state = r_state;
    w_start_load = 1'b0;
    w_start_save = 1'b0;
    w_lba_inc    = 1'b0;
    w_timeout    = 1'b0;
    w_done       = 1'b0;
    w_wd_inc     = 1'b0;
    sd_rd        = 1'b0;
    sd_wr        = 1'b0;
    bk_wr        = 1'b0;
    bk_addr      = 17'd0;
    case (r_state)
      IDLE: begin
        if (w_load_ok) begin
          w_next_state = RD_REQ;
          w_start_load = 1'b1;
        end else if (r_pending || w_save_qual) begin
          w_next_state = WR_REQ;
          w_start_save = 1'b1;
        end
      end
      RD_REQ: begin
        sd_rd = 1'b1;
        if (sd_ack) begin
          w_next_state = RD_XFER;
        end else if (w_wd_last) begin
          w_next_state = IDLE;
          w_timeout    = 1'b1;
        end else begin
          w_wd_inc = 1'b1;
        end
      end
      RD_XFER: begin
        bk_addr = {1'b0, r_lba, sd_buff_addr};
        bk_wr   = sd_buff_wr & sd_ack;
        if (!sd_ack) w_next_state = NEXT;
      end
      WR_REQ: begin
        sd_wr = 1'b1;
        if (sd_ack) begin
          w_next_state = WR_XFER;
        end else if (w_wd_last) begin
          w_next_state = IDLE;
          w_timeout    = 1'b1;
        end else begin
          w_wd_inc = 1'b1;
        end
      end
      WR_XFER: begin
        bk_addr = {1'b0, r_lba, sd_buff_addr};
        if (!sd_ack) w_next_state = NEXT;
      end
      NEXT: begin
        if (r_lba == r_mask) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
        end else begin
          w_lba_inc    = 1'b1;
          w_next_state = r_loading ? RD_REQ : WR_REQ;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_lba        <= 8'd0;
      r_mask       <= 8'd0;
      r_pending    <= 1'b0;
      r_wd         <= '0;
      r_loading    <= 1'b0;
      r_error      <= 1'b0;
      r_save_req_d <= 1'b0;
    end else begin
      r_save_req_d <= bk_save_req;

      // A qualifying save that cannot start now is remembered until IDLE.
      if (w_start_save) begin
        r_pending <= 1'b0;
      end else if (w_save_qual) begin
        r_pending <= 1'b1;
      end

      if (w_start_load || w_start_save) begin
        r_lba   <= 8'd0;
        r_mask  <= ram_mask_file;
        r_error <= 1'b0;
      end else if (w_lba_inc) begin
        r_lba <= r_lba + 8'd1;
      end

      if (w_start_load || w_start_save || w_lba_inc) begin
        r_wd <= '0;
      end else if (w_wd_inc) begin
        r_wd <= r_wd + 1'b1;
      end

      if (w_start_load) begin
        r_loading <= 1'b1;
      end else if (w_start_save || w_done || w_timeout) begin
        r_loading <= 1'b0;
      end

      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign sd_lba      = {24'd0, r_lba};
  assign sd_buff_din = bk_q;
  assign bk_data     = sd_buff_dout;
  assign bk_loading  = r_loading;
  assign bk_busy     = (r_state != IDLE);
  assign bk_error    = r_error;

endmodule

// File: tb/tb_bk_save_ctrl.sv
// tb/tb_bk_save_ctrl.sv - directed/random bench for bk_save_ctrl with SD host and cart RAM models
module tb_bk_save_ctrl;

  logic        clk_sys;
  logic        reset;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic        has_save;
  logic [7:0]  ram_mask_file;
  logic        bk_save_req;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] bk_q;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic [15:0] sd_buff_din;
  logic [16:0] bk_addr;
  logic [15:0] bk_data;
  logic        bk_wr;
  logic        bk_loading;
  logic        bk_busy;
  logic        bk_error;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [15:0] cap  [0:65535];
  logic [15:0] wram [0:65535];

  bk_save_ctrl #(.TIMEOUT_W(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .has_save     (has_save),
    .ram_mask_file(ram_mask_file),
    .bk_save_req  (bk_save_req),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .bk_q         (bk_q),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_buff_din  (sd_buff_din),
    .bk_addr      (bk_addr),
    .bk_data      (bk_data),
    .bk_wr        (bk_wr),
    .bk_loading   (bk_loading),
    .bk_busy      (bk_busy),
    .bk_error     (bk_error)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Cart RAM: writes land in cap, reads come from wram with one cycle of latency.
  always @(posedge clk_sys) begin
    bk_q <= wram[bk_addr[15:0]];
    if (bk_wr) begin
      cap[bk_addr[15:0]] <= bk_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] pat(input logic [15:0] seed, input logic [7:0] l, input logic [7:0] a);
    logic [15:0] x;
    x = {l, a};
    return (x * 16'h9E37) ^ seed ^ {a, l};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // SD host: wait for a request, ack after lat cycles, move one 256-word sector.
  task automatic serve(input bit is_rd, input logic [7:0] exp_lba, input logic [15:0] seed, input int lat);
    int n;
    int bad;
    n = 0;
    while (((is_rd ? sd_rd : sd_wr) !== 1'b1) && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("req_seen", 64'(n < 100), 64'd1);
    if (n >= 100) return;
    check("sd_lba", 64'(sd_lba), {56'd0, exp_lba});
    cyc(lat);
    check("req_held", 64'(is_rd ? sd_rd : sd_wr), 64'd1);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check("req_drop", 64'(is_rd ? sd_rd : sd_wr), 64'd0);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (is_rd && $urandom_range(0, 7) == 0) begin
        sd_buff_wr   = 1'b0;
        sd_buff_addr = 8'($urandom);
        sd_buff_dout = 16'($urandom);
        @(negedge clk_sys);
      end
      sd_buff_addr = 8'(a);
      if (is_rd) begin
        sd_buff_dout = pat(seed, exp_lba, 8'(a));
        sd_buff_wr   = 1'b1;
      end
      @(negedge clk_sys);
      if (!is_rd && sd_buff_din !== pat(seed, exp_lba, 8'(a))) bad++;
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    @(negedge clk_sys);
    if (!is_rd) check("wr_data_bad_words", 64'(bad), 64'd0);
  endtask

  task automatic quiet_window(input string tag, input bit watch_wr);
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if ((watch_wr ? sd_wr : sd_rd) !== 1'b0 || bk_busy !== 1'b0) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  task automatic run_load(input logic [7:0] mask, input logic [15:0] seed);
    int wr0;
    int bad;
    int nwords;
    wr0 = wr_cnt;
    nwords = (int'(mask) + 1) * 256;
    ram_mask_file = mask;
    img_size      = 64'(nwords * 2);
    has_save      = 1'b1;
    img_readonly  = 1'($urandom);
    img_mounted   = 1'b1;
    @(negedge clk_sys);
    img_mounted   = 1'b0;
    check("load_start_loading", 64'(bk_loading), 64'd1);
    check("load_start_busy", 64'(bk_busy), 64'd1);
    check("load_start_error", 64'(bk_error), 64'd0);
    ram_mask_file = ~mask;
    for (int s = 0; s <= int'(mask); s++) serve(1'b1, 8'(s), seed, $urandom_range(0, 6));
    @(negedge clk_sys);
    check("load_end_loading", 64'(bk_loading), 64'd0);
    quiet_window("load_no_extra_rd", 1'b0);
    check("load_wr_count", 64'(wr_cnt - wr0), 64'(nwords));
    bad = 0;
    for (int i = 0; i < nwords; i++)
      if (cap[i] !== pat(seed, 8'(i >> 8), 8'(i))) bad++;
    check("load_data_bad_words", 64'(bad), 64'd0);
  endtask

  task automatic fill_wram(input logic [15:0] seed);
    for (int i = 0; i < 65536; i++) wram[i] = pat(seed, 8'(i >> 8), 8'(i));
  endtask

  task automatic run_save(input logic [7:0] mask, input logic [15:0] seed);
    fill_wram(seed);
    ram_mask_file = mask;
    img_size      = 64'd2048;
    has_save      = 1'b1;
    img_readonly  = 1'b0;
    bk_save_req   = 1'b1;
    @(negedge clk_sys);
    check("save_start_wr", 64'(sd_wr), 64'd1);
    check("save_start_loading", 64'(bk_loading), 64'd0);
    ram_mask_file = ~mask;
    for (int s = 0; s <= int'(mask); s++) serve(1'b0, 8'(s), seed, $urandom_range(0, 6));
    bk_save_req = 1'b0;
    @(negedge clk_sys);
    quiet_window("save_no_extra_wr", 1'b1);
  endtask

  initial begin
    int n;
    int snap;
    int bad;
    logic [15:0] seed_a;
    logic [15:0] seed_b;

    reset = 1'b1; img_mounted = 1'b0; img_readonly = 1'b0; img_size = 64'd0;
    has_save = 1'b0; ram_mask_file = 8'd0; bk_save_req = 1'b0; sd_ack = 1'b0;
    sd_buff_addr = 8'd0; sd_buff_dout = 16'd0; sd_buff_wr = 1'b0;
    cyc(3);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_sd_rd", 64'(sd_rd), 64'd0);
    check("rst_sd_wr", 64'(sd_wr), 64'd0);
    check("rst_bk_wr", 64'(bk_wr), 64'd0);
    check("rst_loading", 64'(bk_loading), 64'd0);
    check("rst_busy", 64'(bk_busy), 64'd0);
    check("rst_error", 64'(bk_error), 64'd0);
    check("rst_sd_lba", 64'(sd_lba), 64'd0);
    check("rst_bk_addr", 64'(bk_addr), 64'd0);

    run_load(8'h0F, 16'($urandom));
    for (int k = 0; k < 3; k++) run_load(8'($urandom_range(0, 3)), 16'($urandom));

    run_save(8'h03, 16'($urandom));
    for (int k = 0; k < 2; k++) run_save(8'($urandom_range(0, 3)), 16'($urandom));

    img_readonly = 1'b1; has_save = 1'b1; img_size = 64'd2048;
    bk_save_req = 1'b1;
    quiet_window("readonly_no_save", 1'b1);
    bk_save_req = 1'b0; img_readonly = 1'b0; has_save = 1'b0;
    @(negedge clk_sys);
    bk_save_req = 1'b1;
    quiet_window("nosave_no_save", 1'b1);
    bk_save_req = 1'b0; has_save = 1'b1;
    @(negedge clk_sys);

    // Save requested mid-load must start one cycle after the load reaches IDLE.
    seed_a = 16'($urandom);
    seed_b = 16'($urandom);
    fill_wram(seed_b);
    ram_mask_file = 8'h01; img_size = 64'd1024;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    bk_save_req = 1'b1;
    serve(1'b1, 8'd0, seed_a, 2);
    serve(1'b1, 8'd1, seed_a, 1);
    @(negedge clk_sys);
    check("pend_idle_busy", 64'(bk_busy), 64'd0);
    check("pend_idle_loading", 64'(bk_loading), 64'd0);
    @(negedge clk_sys);
    check("pend_start_wr", 64'(sd_wr), 64'd1);
    check("pend_start_lba", 64'(sd_lba), 64'd0);
    serve(1'b0, 8'd0, seed_b, 0);
    serve(1'b0, 8'd1, seed_b, 3);
    bk_save_req = 1'b0;
    @(negedge clk_sys);
    quiet_window("pend_single_save", 1'b1);

    ram_mask_file = 8'h00;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    n = 0;
    while (sd_rd === 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("timeout_rd_cycles", 64'(n), 64'd15);
    check("timeout_error", 64'(bk_error), 64'd1);
    check("timeout_loading", 64'(bk_loading), 64'd0);
    check("timeout_busy", 64'(bk_busy), 64'd0);
    fill_wram(seed_a);
    bk_save_req = 1'b1;
    @(negedge clk_sys);
    check("error_cleared_on_start", 64'(bk_error), 64'd0);
    serve(1'b0, 8'd0, seed_a, 1);
    bk_save_req = 1'b0;
    cyc(2);

    // Reset in the middle of sector 5 of a load with ack still high.
    ram_mask_file = 8'h0F; img_size = 64'd8192;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    for (int s = 0; s < 5; s++) serve(1'b1, 8'(s), seed_b, 1);
    n = 0;
    while (sd_rd !== 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("mid_lba5", 64'(sd_lba), 64'd5);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    for (int a = 0; a < 10; a++) begin
      sd_buff_addr = 8'(a); sd_buff_dout = 16'($urandom); sd_buff_wr = 1'b1;
      @(negedge clk_sys);
    end
    reset = 1'b1;
    @(negedge clk_sys);
    check("mid_rst_bk_wr", 64'(bk_wr), 64'd0);
    check("mid_rst_busy", 64'(bk_busy), 64'd0);
    check("mid_rst_loading", 64'(bk_loading), 64'd0);
    check("mid_rst_sd_rd", 64'(sd_rd), 64'd0);
    check("mid_rst_bk_addr", 64'(bk_addr), 64'd0);
    check("mid_rst_sd_lba", 64'(sd_lba), 64'd0);
    snap = wr_cnt;
    reset = 1'b0;
    bad = 0;
    for (int a = 10; a < 30; a++) begin
      sd_buff_addr = 8'(a);
      @(negedge clk_sys);
      if (bk_busy !== 1'b0 || bk_wr !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) bad++;
    end
    check("post_rst_ack_ignored", 64'(bad), 64'd0);
    check("post_rst_no_writes", 64'(wr_cnt - snap), 64'd0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    check("post_rst_idle", 64'(bk_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
